mdu_ctrl: RTL

//   Sequences the multiply/divide unit in the EX stage: accepts one HI/LO op per start,

---
 rtl/mdu_pkg.sv | 39 +++
 rtl/mdu_alu.sv | 63 ++++++
 rtl/mdu_ctrl.sv | 96 +++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op codes, FSM states, counter width.
// MDU_MADD_EN enables the accumulate ops (MADD/MADDU/MSUB/MSUBU).
package mdu_pkg;

    typedef logic [3:0] op_t;

    localparam int CNT_W = 4;

    localparam op_t OP_NOP   = 4'd0;
    localparam op_t OP_MULT  = 4'd1;
    localparam op_t OP_MULTU = 4'd2;
    localparam op_t OP_DIV   = 4'd3;
    localparam op_t OP_DIVU  = 4'd4;
    localparam op_t OP_MTHI  = 4'd5;
    localparam op_t OP_MTLO  = 4'd6;
    localparam op_t OP_MADD  = 4'd7;
    localparam op_t OP_MADDU = 4'd8;
    localparam op_t OP_MSUB  = 4'd9;
    localparam op_t OP_MSUBU = 4'd10;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Multi-cycle ops timed by MULT_LAT; accumulate codes count only when built in.
    function automatic logic is_mul_op(input op_t op);
        case (op)
            OP_MULT, OP_MULTU: return 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_div_op(input op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_alu.sv
// Combinational multiply/divide datapath: 64-bit {hi,lo} result from the latched op and operands.
// MDU_MADD_EN adds the {hi,lo} +/- a*b accumulate paths.
module mdu_alu
    import mdu_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
    output logic [63:0] o_result,
    output logic        o_div_zero
);

    logic        w_signed_mul;
    logic        w_signed_div;
    logic [63:0] w_mul_a;
    logic [63:0] w_mul_b;
    logic [63:0] w_prod;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_divisor;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [31:0] w_quot_fix;
    logic [31:0] w_rem_fix;

`ifdef MDU_MADD_EN
    assign w_signed_mul = (i_op == OP_MULT) || (i_op == OP_MADD) || (i_op == OP_MSUB);
`else
    assign w_signed_mul = (i_op == OP_MULT);
`endif
    assign w_signed_div = (i_op == OP_DIV);

    // One shared multiplier: sign- or zero-extend to 64 bits, keep the low 64 product bits.
    assign w_mul_a = w_signed_mul ? {{32{i_a[31]}}, i_a} : {32'd0, i_a};
    assign w_mul_b = w_signed_mul ? {{32{i_b[31]}}, i_b} : {32'd0, i_b};
    assign w_prod  = w_mul_a * w_mul_b;

    // Signed divide runs on magnitudes; 0x80000000 keeps its bit pattern as an unsigned magnitude.
    assign w_a_mag    = (w_signed_div && i_a[31]) ? -i_a : i_a;
    assign w_b_mag    = (w_signed_div && i_b[31]) ? -i_b : i_b;
    assign o_div_zero = is_div_op(i_op) && (i_b == 32'd0);
    assign w_divisor  = o_div_zero ? 32'd1 : w_b_mag;
    assign w_quot     = w_a_mag / w_divisor;
    assign w_rem      = w_a_mag % w_divisor;
    assign w_quot_fix = (w_signed_div && (i_a[31] ^ i_b[31])) ? -w_quot : w_quot;
    assign w_rem_fix  = (w_signed_div && i_a[31]) ? -w_rem : w_rem;

    always_comb begin
        o_result = {i_hi, i_lo};
        case (i_op)
            OP_MULT, OP_MULTU: o_result = w_prod;
            OP_DIV, OP_DIVU:   o_result = {w_rem_fix, w_quot_fix};
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: o_result = {i_hi, i_lo} + w_prod;
            OP_MSUB, OP_MSUBU: o_result = {i_hi, i_lo} - w_prod;
`endif
            default:           o_result = {i_hi, i_lo};
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// EX-stage MDU sequencer: accepts one HI/LO op per start, holds busy for the op latency, commits HI/LO.
// MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU (MULT_LAT timing, accumulate onto HI/LO at commit).
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT - 1);

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_op;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;

    logic             w_accept;
    logic             w_is_mul;
    logic             w_is_div;
    logic [63:0]      w_result;
    logic             w_div_zero;

    assign busy     = (r_state == ST_RUN);
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign w_accept = start & ~flush & ~busy;
    assign w_is_mul = is_mul_op(op);
    assign w_is_div = is_div_op(op);

    mdu_alu u_alu (
        .i_op       (r_op),
        .i_a        (r_a),
        .i_b        (r_b),
        .i_hi       (r_hi),
        .i_lo       (r_lo),
        .o_result   (w_result),
        .o_div_zero (w_div_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_op    <= OP_NOP;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && (w_is_mul || w_is_div)) begin
                        r_op    <= op;
                        r_a     <= a;
                        r_b     <= b;
                        r_cnt   <= w_is_div ? DIV_CNT : MULT_CNT;
                        r_state <= ST_RUN;
                    end else if (w_accept && (op == OP_MTHI)) begin
                        r_hi <= a;
                    end else if (w_accept && (op == OP_MTLO)) begin
                        r_lo <= a;
                    end
                end
                ST_RUN: begin
                    // Last busy cycle: result lands together with busy falling.
                    if (r_cnt == '0) begin
                        r_state <= ST_IDLE;
                        if (!w_div_zero) begin
                            r_hi <= w_result[63:32];
                            r_lo <= w_result[31:0];
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
